// File: rtl/mul8_seq_pkg.sv
// rtl/mul8_seq_pkg.sv - shared encodings and sizes for the sequential 8x8 multiplier
package mul8_seq_pkg;

  localparam int MUL_ITER = 8;
  localparam int MUL_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul8_seq_if.sv
// rtl/mul8_seq_if.sv - start/busy/done handshake bundle for mul8_seq
// Optional flag signals exist only when MUL8_FLAGS_EN is defined.
interface mul8_seq_if;
  import mul8_seq_pkg::*;

  logic                 start;
  logic [MUL_W-1:0]     a;
  logic [MUL_W-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*MUL_W-1:0]   product;
`ifdef MUL8_FLAGS_EN
  logic                 zero;
  logic                 hi_nz;

  modport master (output start, a, b, input busy, done, product, zero, hi_nz);
  modport slave  (input start, a, b, output busy, done, product, zero, hi_nz);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif

endinterface

// File: rtl/adder8.sv
// rtl/adder8.sv - 8-bit ripple adder with carry out, shared by the multiplier datapath
module adder8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mul8_seq.sv
// rtl/mul8_seq.sv - sequential shift-add 8x8 -> 16 multiplier controller
// Optional zero/hi_nz flags are built when MUL8_FLAGS_EN is defined.
module mul8_seq
  import mul8_seq_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mul8_seq_if.slave     bus
);

  state_e             state_q, state_d;
  logic [2:0]         count_q, count_d;
  logic [MUL_W-1:0]   mcand_q, mcand_d;
  logic [MUL_W-1:0]   hi_q, hi_d;
  logic [MUL_W-1:0]   lo_q, lo_d;

  logic [MUL_W-1:0]   add_sum;
  logic               add_cout;
  logic [MUL_W:0]     sum9;

  adder8 u_add (
    .a_i    (hi_q),
    .b_i    (mcand_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum9    = lo_q[0] ? {add_cout, add_sum} : {1'b0, hi_q};

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          mcand_d = bus.a;
          hi_d    = '0;
          lo_d    = bus.b;
          count_d = '0;
          if (SKIP_ZERO && (bus.a == '0 || bus.b == '0)) begin
            lo_d    = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // carry out lands in hi[7] after the right shift, so no bit is lost
        hi_d    = sum9[MUL_W:1];
        lo_d    = {sum9[0], lo_q[MUL_W-1:1]};
        count_d = count_q + 3'd1;
        if (count_q == 3'(MUL_ITER - 1)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = {hi_q, lo_q};

`ifdef MUL8_FLAGS_EN
  logic zero_q;
  logic hi_nz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q  <= 1'b0;
      hi_nz_q <= 1'b0;
    end else begin
      zero_q  <= ({hi_d, lo_d} == '0);
      hi_nz_q <= (hi_d != '0);
    end
  end

  assign bus.zero  = zero_q;
  assign bus.hi_nz = hi_nz_q;
`endif

endmodule
